stoch_queue_engine: RTL and testbench

Synthesizable, parametrised successor to the simulation-only stochastic queue tasks (`$q_initialize`, `$q_add`, `$q_remove`, `$q_exam`, `$q_full`). It holds up to DEPTH jobs, each a job id plus an inform id, in FIFO or LIFO order, and keeps length and wait-time statistics. Commands arrive over a valid/ready request channel and results return over a valid/ready response channel. It sits in the verification-infrastructure layer, where system-task-based models must be replaced by RTL that runs on an emulator.

---
 rtl/stoch_queue_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_stoch_queue_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stoch_queue_engine.sv
// ---------------------------------------------------------------------------
// stoch_queue_engine
//
// Synthesizable stochastic job queue. It holds up to DEPTH jobs
// ({job_id, inform_id[, timestamp]}) in FIFO or LIFO order and keeps
// length and wait-time statistics. Commands are accepted one at a time
// over a valid/ready request channel. Each command runs through
// IDLE -> EXEC -> RESP, and its result is returned over a valid/ready
// response channel.
//
// Optional feature macro: STOCH_Q_WAIT_STATS_EN
//   defined   : per-entry timestamps and a free-running cycle counter are
//               kept; REMOVE returns the wait time; EXAM codes 4 and 5
//               are supported.
//   undefined : no timestamp storage; REMOVE returns rsp_value 0; EXAM
//               codes 4 and 5 answer UNSUPPORTED.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   request handshake
//   cmd_op                0 INIT, 1 ADD, 2 REMOVE, 3 EXAM
//   cmd_qtype             INIT: 1 FIFO, 2 LIFO
//   cmd_max_len           INIT: logical capacity 1..DEPTH
//   cmd_job_id/inform_id  ADD payload
//   cmd_exam_code         EXAM selector
//   rsp_valid/rsp_ready   response handshake
//   rsp_status            0 OK, 1 FULL, 2 NOT_INIT, 3 EMPTY, 4 UNSUP, 5 BAD_LEN
//   rsp_job_id/inform_id  REMOVE result
//   rsp_value             EXAM result or REMOVE wait time
//   full                  length == max_len while initialized
// ---------------------------------------------------------------------------
module stoch_queue_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [1:0]                cmd_qtype,
  input  logic [$clog2(DEPTH):0]    cmd_max_len,
  input  logic [DATA_W-1:0]         cmd_job_id,
  input  logic [DATA_W-1:0]         cmd_inform_id,
  input  logic [2:0]                cmd_exam_code,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2:0]                rsp_status,
  output logic [DATA_W-1:0]         rsp_job_id,
  output logic [DATA_W-1:0]         rsp_inform_id,
  output logic [TS_W-1:0]           rsp_value,
  output logic                      full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  localparam logic [1:0] OP_INIT   = 2'd0;
  localparam logic [1:0] OP_ADD    = 2'd1;
  localparam logic [1:0] OP_REMOVE = 2'd2;
  localparam logic [1:0] OP_EXAM   = 2'd3;

  localparam logic [1:0] QT_FIFO = 2'd1;
  localparam logic [1:0] QT_LIFO = 2'd2;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_FULL     = 3'd1;
  localparam logic [2:0] ST_NOT_INIT = 3'd2;
  localparam logic [2:0] ST_EMPTY    = 3'd3;
  localparam logic [2:0] ST_UNSUP    = 3'd4;
  localparam logic [2:0] ST_BAD_LEN  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Captured command
  logic [1:0]        req_op;
  logic [1:0]        req_qtype;
  logic [LW-1:0]     req_max_len;
  logic [DATA_W-1:0] req_job_id;
  logic [DATA_W-1:0] req_inform_id;
  logic [2:0]        req_code;

  // Queue bookkeeping
  logic              initialized;
  logic              lifo;
  logic [LW-1:0]     max_len;
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [LW-1:0]     length;
  logic [LW-1:0]     max_seen;

  // Entry storage
  logic [DATA_W-1:0] job_mem [DEPTH];
  logic [DATA_W-1:0] inf_mem [DEPTH];

`ifdef STOCH_Q_WAIT_STATS_EN
  logic [TS_W-1:0]   ts_mem [DEPTH];
  logic [TS_W-1:0]   now;
  logic [TS_W-1:0]   min_wait;
  logic [TS_W-1:0]   nxt_min_wait;
  logic [TS_W-1:0]   age;
  logic [TS_W-1:0]   head_age;
`endif

  // Results of the command being executed
  logic [2:0]        ex_status;
  logic [DATA_W-1:0] ex_job;
  logic [DATA_W-1:0] ex_inf;
  logic [TS_W-1:0]   ex_value;
  logic              wr_en;
  logic [AW-1:0]     rd_idx;
  logic              nxt_init;
  logic              nxt_lifo;
  logic [LW-1:0]     nxt_max_len;
  logic [AW-1:0]     nxt_head;
  logic [AW-1:0]     nxt_tail;
  logic [LW-1:0]     nxt_len;
  logic [LW-1:0]     nxt_max_seen;

  // Decode the captured command against the current queue state.
  always_comb begin
    ex_status    = ST_OK;
    ex_job       = {DATA_W{1'b0}};
    ex_inf       = {DATA_W{1'b0}};
    ex_value     = {TS_W{1'b0}};
    wr_en        = 1'b0;
    nxt_init     = initialized;
    nxt_lifo     = lifo;
    nxt_max_len  = max_len;
    nxt_head     = head;
    nxt_tail     = tail;
    nxt_len      = length;
    nxt_max_seen = max_seen;
    // LIFO pops the newest entry just below tail; FIFO pops at head.
    // In LIFO mode head never moves, so head always names the oldest entry.
    if (lifo) begin
      rd_idx = tail - AW'(1);
    end else begin
      rd_idx = head;
    end
`ifdef STOCH_Q_WAIT_STATS_EN
    nxt_min_wait = min_wait;
    age          = now - ts_mem[rd_idx];
    head_age     = now - ts_mem[head];
`endif

    case (req_op)
      OP_INIT: begin
        if ((req_qtype != QT_FIFO) && (req_qtype != QT_LIFO)) begin
          ex_status = ST_UNSUP;
        end else if ((req_max_len == {LW{1'b0}}) || (req_max_len > DEPTH_L)) begin
          ex_status = ST_BAD_LEN;
        end else begin
          nxt_init     = 1'b1;
          nxt_lifo     = (req_qtype == QT_LIFO);
          nxt_max_len  = req_max_len;
          nxt_head     = {AW{1'b0}};
          nxt_tail     = {AW{1'b0}};
          nxt_len      = {LW{1'b0}};
          nxt_max_seen = {LW{1'b0}};
`ifdef STOCH_Q_WAIT_STATS_EN
          nxt_min_wait = {TS_W{1'b1}};
`endif
        end
      end

      OP_ADD: begin
        if (!initialized) begin
          ex_status = ST_NOT_INIT;
        end else if (length == max_len) begin
          ex_status = ST_FULL;
        end else begin
          wr_en    = 1'b1;
          nxt_tail = tail + AW'(1);
          nxt_len  = length + LW'(1);
          if (nxt_len > max_seen) begin
            nxt_max_seen = nxt_len;
          end else begin
            nxt_max_seen = max_seen;
          end
        end
      end

      OP_REMOVE: begin
        if (!initialized) begin
          ex_status = ST_NOT_INIT;
        end else if (length == {LW{1'b0}}) begin
          ex_status = ST_EMPTY;
        end else begin
          ex_job  = job_mem[rd_idx];
          ex_inf  = inf_mem[rd_idx];
          nxt_len = length - LW'(1);
          if (lifo) begin
            nxt_tail = tail - AW'(1);
          end else begin
            nxt_head = head + AW'(1);
          end
`ifdef STOCH_Q_WAIT_STATS_EN
          ex_value = age;
          if (age < min_wait) begin
            nxt_min_wait = age;
          end else begin
            nxt_min_wait = min_wait;
          end
`endif
        end
      end

      OP_EXAM: begin
        if (!initialized) begin
          ex_status = ST_NOT_INIT;
        end else begin
          case (req_code)
            3'd1: ex_value = TS_W'(length);
            3'd3: ex_value = TS_W'(max_seen);
`ifdef STOCH_Q_WAIT_STATS_EN
            3'd4: ex_value = min_wait;
            3'd5: begin
              if (length == {LW{1'b0}}) begin
                ex_value = {TS_W{1'b0}};
              end else begin
                ex_value = head_age;
              end
            end
`endif
            default: ex_status = ST_UNSUP;
          endcase
        end
      end

      default: ex_status = ST_UNSUP;
    endcase
  end

  // Command FSM: handshake, state update in EXEC, registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_status    <= 3'd0;
      rsp_job_id    <= {DATA_W{1'b0}};
      rsp_inform_id <= {DATA_W{1'b0}};
      rsp_value     <= {TS_W{1'b0}};
      full          <= 1'b0;
      req_op        <= 2'd0;
      req_qtype     <= 2'd0;
      req_max_len   <= {LW{1'b0}};
      req_job_id    <= {DATA_W{1'b0}};
      req_inform_id <= {DATA_W{1'b0}};
      req_code      <= 3'd0;
      initialized   <= 1'b0;
      lifo          <= 1'b0;
      max_len       <= {LW{1'b0}};
      head          <= {AW{1'b0}};
      tail          <= {AW{1'b0}};
      length        <= {LW{1'b0}};
      max_seen      <= {LW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            req_op        <= cmd_op;
            req_qtype     <= cmd_qtype;
            req_max_len   <= cmd_max_len;
            req_job_id    <= cmd_job_id;
            req_inform_id <= cmd_inform_id;
            req_code      <= cmd_exam_code;
            cmd_ready     <= 1'b0;
            state         <= EXEC;
          end else begin
            cmd_ready     <= 1'b1;
          end
        end

        EXEC: begin
          initialized   <= nxt_init;
          lifo          <= nxt_lifo;
          max_len       <= nxt_max_len;
          head          <= nxt_head;
          tail          <= nxt_tail;
          length        <= nxt_len;
          max_seen      <= nxt_max_seen;
          full          <= nxt_init && (nxt_len == nxt_max_len);
          rsp_status    <= ex_status;
          rsp_job_id    <= ex_job;
          rsp_inform_id <= ex_inf;
          rsp_value     <= ex_value;
          rsp_valid     <= 1'b1;
          state         <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid     <= 1'b0;
            rsp_status    <= 3'd0;
            rsp_job_id    <= {DATA_W{1'b0}};
            rsp_inform_id <= {DATA_W{1'b0}};
            rsp_value     <= {TS_W{1'b0}};
            cmd_ready     <= 1'b1;
            state         <= IDLE;
          end else begin
            rsp_valid     <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage write; contents need no reset because length gates every read.
  always_ff @(posedge clk) begin
    if ((state == EXEC) && wr_en) begin
      job_mem[tail] <= req_job_id;
      inf_mem[tail] <= req_inform_id;
`ifdef STOCH_Q_WAIT_STATS_EN
      ts_mem[tail]  <= now;
`endif
    end
  end

`ifdef STOCH_Q_WAIT_STATS_EN
  // Free-running cycle timestamp and shortest-wait statistic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      now      <= {TS_W{1'b0}};
      min_wait <= {TS_W{1'b1}};
    end else begin
      now <= now + TS_W'(1);
      if (state == EXEC) begin
        min_wait <= nxt_min_wait;
      end else begin
        min_wait <= min_wait;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stoch_queue_engine.sv
// Self-checking bench for stoch_queue_engine: directed scenarios plus
// randomized commands, all checked against a queue-based reference model.
module tb_stoch_queue_engine;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 32;
  localparam int LW     = $clog2(DEPTH) + 1;
`ifdef STOCH_Q_WAIT_STATS_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_qtype;
  logic [LW-1:0]     cmd_max_len;
  logic [DATA_W-1:0] cmd_job_id;
  logic [DATA_W-1:0] cmd_inform_id;
  logic [2:0]        cmd_exam_code;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_status;
  logic [DATA_W-1:0] rsp_job_id;
  logic [DATA_W-1:0] rsp_inform_id;
  logic [TS_W-1:0]   rsp_value;
  logic              full;

  stoch_queue_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_qtype(cmd_qtype), .cmd_max_len(cmd_max_len),
    .cmd_job_id(cmd_job_id), .cmd_inform_id(cmd_inform_id),
    .cmd_exam_code(cmd_exam_code),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_job_id(rsp_job_id), .rsp_inform_id(rsp_inform_id),
    .rsp_value(rsp_value), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] job;
    logic [31:0] inf;
    longint      stamp;
  } ent_t;

  ent_t        mq[$];
  bit          m_init = 1'b0;
  bit          m_lifo = 1'b0;
  int          m_max_len = 0;
  int          m_max_seen = 0;
  logic [31:0] m_min_wait = 32'hFFFF_FFFF;

  task automatic model_reset();
    mq.delete();
    m_init = 1'b0; m_lifo = 1'b0; m_max_len = 0; m_max_seen = 0;
    m_min_wait = 32'hFFFF_FFFF;
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [1:0] qt, input int ml,
                           input logic [31:0] jid, input logic [31:0] iid,
                           input logic [2:0] code, input longint t,
                           output logic [2:0] st, output logic [31:0] j,
                           output logic [31:0] i, output logic [31:0] v);
    ent_t e;
    logic [31:0] w;
    st = 3'd0; j = 32'd0; i = 32'd0; v = 32'd0;
    case (op)
      2'd0: begin
        if (qt != 2'd1 && qt != 2'd2) st = 3'd4;
        else if (ml == 0 || ml > DEPTH) st = 3'd5;
        else begin
          mq.delete(); m_init = 1'b1; m_lifo = (qt == 2'd2); m_max_len = ml;
          m_max_seen = 0; m_min_wait = 32'hFFFF_FFFF;
        end
      end
      2'd1: begin
        if (!m_init) st = 3'd2;
        else if (mq.size() == m_max_len) st = 3'd1;
        else begin
          e.job = jid; e.inf = iid; e.stamp = t;
          mq.push_back(e);
          if (mq.size() > m_max_seen) m_max_seen = mq.size();
        end
      end
      2'd2: begin
        if (!m_init) st = 3'd2;
        else if (mq.size() == 0) st = 3'd3;
        else begin
          if (m_lifo) e = mq.pop_back();
          else e = mq.pop_front();
          j = e.job; i = e.inf;
          w = 32'(t - e.stamp);
          if (WAIT) begin
            v = w;
            if (w < m_min_wait) m_min_wait = w;
          end
        end
      end
      default: begin
        if (!m_init) st = 3'd2;
        else if (code == 3'd1) v = 32'(mq.size());
        else if (code == 3'd3) v = 32'(m_max_seen);
        else if (code == 3'd4 && WAIT) v = m_min_wait;
        else if (code == 3'd5 && WAIT) v = (mq.size() == 0) ? 32'd0 : 32'(t - mq[0].stamp);
        else st = 3'd4;
      end
    endcase
  endtask

  // ---------------- command driver ----------------
  logic [31:0] last_val;
  longint      last_t;

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] qt, input int ml,
                         input logic [31:0] jid, input logic [31:0] iid,
                         input logic [2:0] code, input int hold);
    int n;
    int lat;
    logic [2:0]  est;
    logic [31:0] ej, ei, ev;
    @(negedge clk);
    cmd_op = op; cmd_qtype = qt; cmd_max_len = LW'(ml); cmd_job_id = jid;
    cmd_inform_id = iid; cmd_exam_code = code; cmd_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check_eq("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    last_t = cyc;
    model_cmd(op, qt, ml, jid, iid, code, cyc, est, ej, ei, ev);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    check_eq("rsp_latency", 64'(lat), 64'd2);
    check_eq("status", 64'(rsp_status), 64'(est));
    check_eq("job_id", 64'(rsp_job_id), 64'(ej));
    check_eq("inform_id", 64'(rsp_inform_id), 64'(ei));
    check_eq("value", 64'(rsp_value), 64'(ev));
    check_eq("full", 64'(full), 64'(m_init && mq.size() == m_max_len));
    last_val = rsp_value;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_value", 64'(rsp_value), 64'(ev));
      check_eq("hold_job", 64'(rsp_job_id), 64'(ej));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_init(input logic [1:0] qt, input int ml);
    run_cmd(2'd0, qt, ml, 32'd0, 32'd0, 3'd0, 0);
  endtask
  task automatic do_add(input logic [31:0] j, input logic [31:0] i);
    run_cmd(2'd1, 2'd0, 0, j, i, 3'd0, 0);
  endtask
  task automatic do_rem();
    run_cmd(2'd2, 2'd0, 0, 32'd0, 32'd0, 3'd0, 0);
  endtask
  task automatic do_exam(input logic [2:0] c);
    run_cmd(2'd3, 2'd0, 0, 32'd0, 32'd0, c, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t_add;
    int     n;
    int     adds;
    int     r;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = 2'd0;
    cmd_qtype = 2'd0; cmd_max_len = '0; cmd_job_id = 32'd0;
    cmd_inform_id = 32'd0; cmd_exam_code = 3'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("reset_full", 64'(full), 64'd0);
    check_eq("reset_status", 64'(rsp_status), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", 64'(cmd_ready), 64'd1);

    // Error handling before initialization
    do_add(32'd5, 32'd6);
    do_init(2'd3, 4);
    do_init(2'd1, 0);
    do_exam(3'd1);

    // FIFO, capacity 4
    do_init(2'd1, 4);
    for (int k = 10; k < 14; k++) do_add(32'(k), 32'(k + 100));
    check_eq("fifo_full_flag", 64'(full), 64'd1);
    do_add(32'd14, 32'd0);
    for (int k = 0; k < 5; k++) do_rem();

    // LIFO, capacity 16
    do_init(2'd2, 16);
    for (int k = 1; k <= 20; k++) do_add(32'(k), 32'(k * 3));
    for (int k = 0; k < 16; k++) do_rem();
    do_exam(3'd3);

    // FIFO pointer wrap
    do_init(2'd1, DEPTH);
    adds = 0;
    while (adds < 40) begin
      do_add(32'(1000 + adds), 32'(adds)); adds++;
      do_add(32'(1000 + adds), 32'(adds)); adds++;
      do_rem();
    end
    for (int k = 0; k < DEPTH + 1; k++) do_rem();

    // Wait statistics
    do_init(2'd1, 4);
    run_cmd(2'd1, 2'd0, 0, 32'hABCD, 32'h1234, 3'd0, 5);
    t_add = last_t;
    repeat (10) @(negedge clk);
    do_exam(3'd5);
    do_rem();
    check_eq("wait_delta", 64'(last_val), WAIT ? 64'(last_t - t_add) : 64'd0);
    do_exam(3'd4);
    do_exam(3'd5);

    // Reset during RESP of an ADD
    do_init(2'd1, 1);
    @(negedge clk);
    cmd_op = 2'd1; cmd_job_id = 32'd77; cmd_inform_id = 32'd78; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check_eq("mid_rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("mid_full", 64'(full), 64'd1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("abort_full", 64'(full), 64'd0);
    check_eq("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_back", 64'(cmd_ready), 64'd1);
    do_exam(3'd1);
    do_rem();

    // Randomized traffic
    do_init(2'd1, 8);
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 5)
        run_cmd(2'd0, 2'($urandom_range(0, 3)), $urandom_range(0, 17), 32'd0, 32'd0, 3'd0, 0);
      else if (r < 50)
        run_cmd(2'd1, 2'd0, 0, $urandom, $urandom, 3'd0, $urandom_range(0, 2));
      else if (r < 80)
        run_cmd(2'd2, 2'd0, 0, 32'd0, 32'd0, 3'd0, $urandom_range(0, 2));
      else
        run_cmd(2'd3, 2'd0, 0, 32'd0, 32'd0, 3'($urandom_range(0, 7)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
